// File: rtl/conv_window_gen_pkg.sv
// Shared constants, FSM encoding and a width helper for the 3x3 window generator.
package conv_pkg;

  localparam int PIX_W          = 8;
  localparam int WORD_W         = 64;
  localparam int WIN_W          = 72;
  localparam int BYTES_PER_WORD = WORD_W / PIX_W;
  localparam int LANE_BYTES     = 16;
  localparam int LANE_PTR_W     = 4;
  localparam int LANE_CNT_W     = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_FETCH    = 2'd1;
  localparam state_t ST_WAIT_ROW = 2'd2;
  localparam state_t ST_DONE     = 2'd3;

  // Bits needed to hold the value max_val (never less than one bit).
  function automatic int cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// BRAM read port plus window valid/ready stream of the window generator.
interface conv_window_gen_if #(
  parameter int ADDR_W = 8
) ();
  import conv_pkg::*;

  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [WORD_W-1:0] doutb;
  logic [WIN_W-1:0]  window_data;
  logic              window_valid;
  logic              window_ready;

  modport master (
    output enb, addrb, window_data, window_valid,
    input  doutb, window_ready
  );

  modport slave (
    input  enb, addrb, window_data, window_valid,
    output doutb, window_ready
  );

endinterface

// File: rtl/conv_window_gen_lane.sv
// One kernel-row lane: 16-byte ring, written 8 bytes at a time, read as a 3-byte row.
module row_lane_buf
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WORD_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [LANE_CNT_W-1:0] count,
  output logic [3*PIX_W-1:0]    row_out
);

  logic [PIX_W-1:0]      ring [LANE_BYTES];
  logic [LANE_PTR_W-1:0] wr_ptr;
  logic [LANE_PTR_W-1:0] rd_ptr;

  // Store a pushed word as eight consecutive ring bytes starting at the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANE_BYTES; i++) ring[i] <= '0;
    end else if (push && !flush) begin
      for (int k = 0; k < BYTES_PER_WORD; k++)
        ring[wr_ptr + LANE_PTR_W'(k)] <= push_data[PIX_W*k +: PIX_W];
    end
  end

  // Pointer and occupancy bookkeeping; a flush empties the lane at the end of a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LANE_PTR_W'(BYTES_PER_WORD);
      if (pop)  rd_ptr <= rd_ptr + LANE_PTR_W'(1);
      count <= count + (push ? LANE_CNT_W'(BYTES_PER_WORD) : LANE_CNT_W'(0))
                     - (pop  ? LANE_CNT_W'(1) : LANE_CNT_W'(0));
    end
  end

  // Three bytes from the read pointer; the mod-16 pointer lets a row span bytes 15,0,1.
  always_comb begin
    row_out = '0;
    for (int j = 0; j < 3; j++)
      row_out[PIX_W*j +: PIX_W] = ring[rd_ptr + LANE_PTR_W'(j)];
  end

endmodule

// File: rtl/conv_window_gen.sv
// Reads a raster image from BRAM into three row lanes and streams every 3x3 window.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  conv_window_gen_if.master bus
);

  localparam int WPR        = IMG_W / 8;
  localparam int BAND_W     = cnt_bits(IMG_H - 3);
  localparam int WORD_IDX_W = cnt_bits(WPR - 1);
  localparam int COL_W      = cnt_bits(IMG_W - 3);

  state_t                state;
  logic [BAND_W-1:0]     band;
  logic [WORD_IDX_W-1:0] word_idx;
  logic [1:0]            lane;
  logic [COL_W-1:0]      col;
  logic                  rd_pending;
  logic [1:0]            rd_tag;

  logic [LANE_CNT_W-1:0] lane_count [3];
  logic [3*PIX_W-1:0]    lane_row   [3];
  logic [LANE_CNT_W-1:0] sel_count;
  logic [LANE_CNT_W-1:0] sel_inflight;
  logic                  read_ok;
  logic                  handshake;
  logic                  row_end;
  logic                  pop_all;

  // Decide whether the current lane may take another word without overflowing its ring.
  always_comb begin
    sel_count = lane_count[2];
    case (lane)
      2'd0:    sel_count = lane_count[0];
      2'd1:    sel_count = lane_count[1];
      default: sel_count = lane_count[2];
    endcase
    sel_inflight = (rd_pending && (rd_tag == lane)) ? LANE_CNT_W'(BYTES_PER_WORD) : '0;
    read_ok      = (state == ST_FETCH) && ((sel_count + sel_inflight) <= LANE_CNT_W'(8));
  end

  assign bus.enb   = read_ok;
  assign bus.addrb = read_ok ? ADDR_W'((int'(band) + int'(lane)) * WPR + int'(word_idx)) : '0;

  assign bus.window_valid = (lane_count[0] >= LANE_CNT_W'(3)) &&
                            (lane_count[1] >= LANE_CNT_W'(3)) &&
                            (lane_count[2] >= LANE_CNT_W'(3));
  assign bus.window_data  = {lane_row[2], lane_row[1], lane_row[0]};

  assign handshake = bus.window_valid && bus.window_ready;
  assign row_end   = handshake && (col == COL_W'(IMG_W - 3));
  assign pop_all   = handshake && !row_end;

  assign busy = (state == ST_FETCH) || (state == ST_WAIT_ROW);
  assign done = (state == ST_DONE);

  for (genvar g = 0; g < 3; g++) begin : g_lane
    row_lane_buf u_lane (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_pending && (rd_tag == 2'(g))),
      .push_data (bus.doutb),
      .pop       (pop_all),
      .flush     (row_end),
      .count     (lane_count[g]),
      .row_out   (lane_row[g])
    );
  end

  // Frame sequencing: fetch each band word by word in lane order, then wait for the row flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      band     <= '0;
      word_idx <= '0;
      lane     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            band     <= '0;
            word_idx <= '0;
            lane     <= '0;
          end
        end
        ST_FETCH: begin
          if (read_ok) begin
            if (lane == 2'd2) begin
              lane <= '0;
              if (word_idx == WORD_IDX_W'(WPR - 1)) state <= ST_WAIT_ROW;
              else word_idx <= word_idx + WORD_IDX_W'(1);
            end else begin
              lane <= lane + 2'd1;
            end
          end
        end
        ST_WAIT_ROW: begin
          if (row_end) begin
            if (band == BAND_W'(IMG_H - 3)) begin
              state <= ST_DONE;
            end else begin
              band     <= band + BAND_W'(1);
              word_idx <= '0;
              lane     <= '0;
              state    <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Remember which lane a read belongs to so the returning word lands in the right ring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_tag     <= '0;
    end else begin
      rd_pending <= read_ok;
      rd_tag     <= lane;
    end
  end

  // Output column within the band; wraps to zero on the row-end handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          col <= '0;
    else if (row_end)   col <= '0;
    else if (handshake) col <= col + COL_W'(1);
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench: directed frames on a 16x4 and a 24x3 image with BRAM models.
`timescale 1ns/1ps
module tb_conv_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, start_a, busy_a, done_a;
  logic reset_b, start_b, busy_b, done_b;

  conv_window_gen_if #(.ADDR_W(8)) bus_a ();
  conv_window_gen_if #(.ADDR_W(8)) bus_b ();

  conv_window_gen #(.IMG_W(16), .IMG_H(4), .ADDR_W(8)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  conv_window_gen #(.IMG_W(24), .IMG_H(3), .ADDR_W(8)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  logic [63:0] mem_a [8];
  logic [63:0] mem_b [9];

  // BRAM models with one cycle read latency.
  always @(posedge clk) begin
    if (bus_a.enb) bus_a.doutb <= (bus_a.addrb < 8'd8) ? mem_a[bus_a.addrb[2:0]] : 64'd0;
    if (bus_b.enb) bus_b.doutb <= (bus_b.addrb < 8'd9) ? mem_b[bus_b.addrb[3:0]] : 64'd0;
  end

  int checks = 0;
  int errors = 0;

  typedef struct { int idx; logic [71:0] win; } win_vec_t;
  typedef struct { int idx; int addr; } addr_vec_t;
  win_vec_t  win_tab  [6];
  addr_vec_t addr_tab [12];

  logic [71:0] win_q [$];
  int          addr_q [$];
  int          done_pulses;

  task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int w, input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[8*(3*i+j) +: 8] = 8'((r + i) * w + c + j);
    return v;
  endfunction

  // Runs one frame on the 16x4 instance, logging windows, addresses and done pulses.
  task automatic apply_stimulus(input int ready_low_pct, input int extra_start_at,
                                input int abort_at, output bit aborted);
    int          hs_cyc;
    int          post;
    bit          finished;
    bit          stall_prev;
    logic [71:0] data_prev;
    win_q.delete();
    addr_q.delete();
    done_pulses = 0;
    aborted     = 1'b0;
    hs_cyc      = -10;
    post        = 0;
    finished    = 1'b0;
    stall_prev  = 1'b0;
    data_prev   = '0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_output("busy_after_start", 72'(busy_a), 72'd1);
    for (int cyc = 0; cyc < 3000 && post < 6; cyc++) begin
      start_a = (cyc == extra_start_at);
      bus_a.window_ready = ($urandom_range(0, 99) >= ready_low_pct);
      if (cyc == abort_at) begin
        reset_a = 1'b1;
        start_a = 1'b0;
        #1;
        check_output("rst_mid_busy",  72'(busy_a), 72'd0);
        check_output("rst_mid_valid", 72'(bus_a.window_valid), 72'd0);
        check_output("rst_mid_data",  bus_a.window_data, 72'd0);
        check_output("rst_mid_enb",   72'(bus_a.enb), 72'd0);
        check_output("rst_mid_addr",  72'(bus_a.addrb), 72'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_output("rst_mid_done", 72'(done_a), 72'd0);
        end
        reset_a = 1'b0;
        @(negedge clk);
        check_output("post_abort_done", 72'(done_a), 72'd0);
        check_output("post_abort_busy", 72'(busy_a), 72'd0);
        bus_a.window_ready = 1'b1;
        aborted = 1'b1;
        return;
      end
      if (stall_prev) begin
        check_output("stall_valid", 72'(bus_a.window_valid), 72'd1);
        check_output("stall_data", bus_a.window_data, data_prev);
      end
      if (bus_a.enb) addr_q.push_back(int'(bus_a.addrb));
      if (done_a) begin
        done_pulses++;
        if (!finished) begin
          check_output("done_after_last_hs", 72'(cyc), 72'(hs_cyc + 1));
          check_output("busy_at_done", 72'(busy_a), 72'd0);
        end
        finished = 1'b1;
      end
      if (finished) post++;
      if (bus_a.window_valid && bus_a.window_ready) begin
        win_q.push_back(bus_a.window_data);
        hs_cyc = cyc;
      end
      stall_prev = bus_a.window_valid && !bus_a.window_ready;
      data_prev  = bus_a.window_data;
      @(negedge clk);
    end
    start_a = 1'b0;
    bus_a.window_ready = 1'b1;
    if (!finished) check_output("frame_a_timeout", 72'd0, 72'd1);
  endtask

  // Compares the logged 16x4 frame against the vector tables and the pixel formula.
  task automatic verify_frame_a();
    check_output("win_count", 72'(win_q.size()), 72'd28);
    check_output("done_once", 72'(done_pulses), 72'd1);
    for (int v = 0; v < 6; v++) begin
      if (win_tab[v].idx < win_q.size()) check_output("win_vec", win_q[win_tab[v].idx], win_tab[v].win);
      else check_output("win_vec_missing", 72'd0, win_tab[v].win);
    end
    for (int n = 0; n < win_q.size() && n < 28; n++)
      check_output("win_stream", win_q[n], exp_win(16, n / 14, n % 14));
    check_output("addr_count", 72'(addr_q.size()), 72'd12);
    for (int v = 0; v < 12; v++) begin
      if (addr_tab[v].idx < addr_q.size()) check_output("addr_vec", 72'(addr_q[addr_tab[v].idx]), 72'(addr_tab[v].addr));
      else check_output("addr_vec_missing", 72'd0, 72'(addr_tab[v].addr));
    end
  endtask

  // 24x3 frame with a long stall at column 5 so later windows read across the ring wrap.
  task automatic run_frame_b();
    logic [71:0] wins [$];
    int          post;
    int          stalled;
    int          pulses;
    bit          finished;
    bit          stall_prev;
    logic [71:0] data_prev;
    post       = 0;
    stalled    = 0;
    pulses     = 0;
    finished   = 1'b0;
    stall_prev = 1'b0;
    data_prev  = '0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int cyc = 0; cyc < 3000 && post < 6; cyc++) begin
      bus_b.window_ready = 1'b1;
      if (wins.size() == 5 && stalled < 40) begin
        bus_b.window_ready = 1'b0;
        if (bus_b.window_valid) stalled++;
      end
      if (stall_prev) begin
        check_output("b_stall_valid", 72'(bus_b.window_valid), 72'd1);
        check_output("b_stall_data", bus_b.window_data, data_prev);
      end
      if (done_b) begin
        pulses++;
        finished = 1'b1;
      end
      if (finished) post++;
      if (bus_b.window_valid && bus_b.window_ready) wins.push_back(bus_b.window_data);
      stall_prev = bus_b.window_valid && !bus_b.window_ready;
      data_prev  = bus_b.window_data;
      @(negedge clk);
    end
    if (!finished) check_output("frame_b_timeout", 72'd0, 72'd1);
    check_output("b_stall_len", 72'(stalled), 72'd40);
    check_output("b_win_count", 72'(wins.size()), 72'd22);
    check_output("b_done_once", 72'(pulses), 72'd1);
    // Column 14: rows 0..2 hold pixels 0E..10, 26..28, 3E..40 (pixel = r*24+c).
    if (wins.size() > 14) check_output("b_wrap_c14", wins[14], 72'h40_3F_3E_28_27_26_10_0F_0E);
    else check_output("b_wrap_c14_missing", 72'd0, 72'h40_3F_3E_28_27_26_10_0F_0E);
    for (int n = 0; n < wins.size() && n < 22; n++)
      check_output("b_win_stream", wins[n], exp_win(24, 0, n));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit aborted;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++)
        mem_a[r*2 + c/8][8*(c%8) +: 8] = 8'(r*16 + c);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 24; c++)
        mem_b[r*3 + c/8][8*(c%8) +: 8] = 8'(r*24 + c);

    win_tab[0] = '{0,  72'h22_21_20_12_11_10_02_01_00};
    win_tab[1] = '{1,  72'h23_22_21_13_12_11_03_02_01};
    win_tab[2] = '{7,  72'h29_28_27_19_18_17_09_08_07};
    win_tab[3] = '{13, 72'h2F_2E_2D_1F_1E_1D_0F_0E_0D};
    win_tab[4] = '{14, 72'h32_31_30_22_21_20_12_11_10};
    win_tab[5] = '{27, 72'h3F_3E_3D_2F_2E_2D_1F_1E_1D};
    addr_tab[0]  = '{0, 0};  addr_tab[1]  = '{1, 2};  addr_tab[2]  = '{2, 4};
    addr_tab[3]  = '{3, 1};  addr_tab[4]  = '{4, 3};  addr_tab[5]  = '{5, 5};
    addr_tab[6]  = '{6, 2};  addr_tab[7]  = '{7, 4};  addr_tab[8]  = '{8, 6};
    addr_tab[9]  = '{9, 3};  addr_tab[10] = '{10, 5}; addr_tab[11] = '{11, 7};

    reset_a = 1'b1;
    reset_b = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.window_ready = 1'b1;
    bus_b.window_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_busy",  72'(busy_a), 72'd0);
    check_output("rst_done",  72'(done_a), 72'd0);
    check_output("rst_enb",   72'(bus_a.enb), 72'd0);
    check_output("rst_addrb", 72'(bus_a.addrb), 72'd0);
    check_output("rst_valid", 72'(bus_a.window_valid), 72'd0);
    check_output("rst_data",  bus_a.window_data, 72'd0);
    check_output("rst_b_valid", 72'(bus_b.window_valid), 72'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    check_output("idle_busy", 72'(busy_a), 72'd0);
    check_output("idle_enb",  72'(bus_a.enb), 72'd0);

    $display("[TB] full-rate frame");
    apply_stimulus(0, -1, -1, aborted);
    verify_frame_a();

    $display("[TB] backpressure frame");
    apply_stimulus(30, -1, -1, aborted);
    verify_frame_a();

    $display("[TB] start while busy");
    apply_stimulus(0, 8, -1, aborted);
    verify_frame_a();

    $display("[TB] reset mid-band then fresh frame");
    apply_stimulus(0, -1, 12, aborted);
    check_output("abort_no_done", 72'(done_pulses), 72'd0);
    apply_stimulus(0, -1, -1, aborted);
    verify_frame_a();

    $display("[TB] lane wrap frame");
    run_frame_b();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
